// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch unit with a decoupling instruction queue.
//
// Requests aligned fetch groups from the I-cache. Each returned group is
// trimmed to the slots at or after the fetch PC and written into a small
// circular queue together with the per-instruction PCs. Decode pops one
// instruction per cycle. A branch redirect flushes the queue and retargets
// the fetch PC. A response still in flight when the redirect arrives is
// swallowed in the DRAIN state.
//
// Handshakes (valid/ready, same meaning on every interface):
//   - A transfer happens on a rising clk edge where both valid and ready are 1.
//   - Once cache_req_valid is raised, it stays up and cache_req_addr stays
//     stable until acceptance. The one exception is a redirect, which may
//     withdraw an unaccepted request.
//   - cache_resp_valid is a one-cycle strobe with no ready; exactly one
//     response follows each accepted request.
//   - Decode pops the head entry when out_valid & in_enable.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_branch_taken_bool       redirect strobe
//   in_target                  redirect PC
//   cache_req_valid/addr/ready fetch-group request to the I-cache
//   cache_resp_valid/data      group response; slot 0 is in the LSBs
//   out_valid                  head instruction available
//   out_instruction_bits       head instruction
//   out_pc                     PC of the head instruction
//   in_enable                  decode ready
//
// Optional feature macro: FETCH_HALT_ON_ZERO_EN.
//   When defined, an all-zero instruction word stops enqueueing at that slot.
//   The fetcher then parks in HALT until the next redirect.

module fetch_queue #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int FETCH_WIDTH       = 2,
  parameter int QUEUE_DEPTH       = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_branch_taken_bool,
  input  logic [ADDRESS_WIDTH-1:0]               in_target,
  output logic                                   cache_req_valid,
  output logic [ADDRESS_WIDTH-1:0]               cache_req_addr,
  input  logic                                   cache_req_ready,
  input  logic                                   cache_resp_valid,
  input  logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0] cache_resp_data,
  output logic                                   out_valid,
  output logic [INSTRUCTION_WIDTH-1:0]           out_instruction_bits,
  output logic [ADDRESS_WIDTH-1:0]               out_pc,
  input  logic                                   in_enable
);

  // A depth of 1 still gets a 1-bit pointer over two storage slots. Only one
  // slot is ever occupied, because the occupancy counter caps at QUEUE_DEPTH.
  localparam int PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << PTR_W;
  localparam int SLOT_W    = $clog2(FETCH_WIDTH) + 1;  // holds 0..FETCH_WIDTH
  localparam int GB_SHIFT  = $clog2(FETCH_WIDTH) + 2;  // log2(group bytes)

  localparam logic [ADDRESS_WIDTH-1:0] GROUP_MASK =
    ~((ADDRESS_WIDTH'(1) << GB_SHIFT) - ADDRESS_WIDTH'(1));
  localparam logic [ADDRESS_WIDTH-1:0] GROUP_BYTES = ADDRESS_WIDTH'(FETCH_WIDTH * 4);
  localparam logic [ADDRESS_WIDTH-1:0] SLOT_MASK   = ADDRESS_WIDTH'(FETCH_WIDTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK   = ~ADDRESS_WIDTH'(3);
  localparam logic [CNT_W-1:0]         QD_C        = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]         FW_C        = CNT_W'(FETCH_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
`ifdef FETCH_HALT_ON_ZERO_EN
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
`else
    S_DRAIN = 3'd3
`endif
  } state_t;

  state_t                   state, state_n;
  logic [ADDRESS_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic                     req_valid_q;

  logic [INSTRUCTION_WIDTH-1:0] mem_instr [MEM_DEPTH];
  logic [ADDRESS_WIDTH-1:0]     mem_pc    [MEM_DEPTH];
  logic [PTR_W-1:0]             rd_ptr, wr_ptr, rd_ptr_n;
  logic [CNT_W-1:0]             count, count_n, cnt_after_deq, free_cnt;

  logic                         out_valid_q;
  logic [INSTRUCTION_WIDTH-1:0] out_instr_q;
  logic [ADDRESS_WIDTH-1:0]     out_pc_q;

  logic [ADDRESS_WIDTH-1:0]     group_addr;
  logic [SLOT_W-1:0]            start_slot, avail;
  logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0] shifted;
  logic [INSTRUCTION_WIDTH-1:0] enq_data [FETCH_WIDTH];
  logic [ADDRESS_WIDTH-1:0]     enq_pcs  [FETCH_WIDTH];
  logic [SLOT_W-1:0]            enq_cnt;
  logic                         zero_stop;

  logic req_accept, resp_fire, deq;

  assign cache_req_valid      = req_valid_q;
  assign cache_req_addr       = fetch_pc & GROUP_MASK;
  assign out_valid            = out_valid_q;
  assign out_instruction_bits = out_instr_q;
  assign out_pc               = out_pc_q;

  assign group_addr = fetch_pc & GROUP_MASK;
  assign start_slot = SLOT_W'((fetch_pc >> 2) & SLOT_MASK);
  assign avail      = SLOT_W'(FETCH_WIDTH) - start_slot;
  assign req_accept = req_valid_q & cache_req_ready;
  // A response landing together with a redirect belongs to the old path.
  assign resp_fire  = (state == S_RESP) & cache_resp_valid & ~in_branch_taken_bool;
  assign deq        = out_valid_q & in_enable;
  assign free_cnt   = QD_C - count;

  // Slot trimming: shift the group so the start slot lands in entry 0. Entry
  // i then carries PC (fetch_pc word-aligned) + 4*i.
  always_comb begin
    shifted   = cache_resp_data >> (int'(start_slot) * INSTRUCTION_WIDTH);
    enq_cnt   = '0;
    zero_stop = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_data[i] = shifted[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
      enq_pcs[i]  = (fetch_pc & WORD_MASK) + ADDRESS_WIDTH'(i * 4);
      if ((SLOT_W'(i) < avail) && !zero_stop) begin
`ifdef FETCH_HALT_ON_ZERO_EN
        if (enq_data[i] == '0) zero_stop = 1'b1;
`endif
        if (!zero_stop) enq_cnt = SLOT_W'(i + 1);
      end
    end
  end

  // Next-state logic. The redirect overrides the normal transitions. If an
  // accepted request's response has not yet shown up, the next state is
  // DRAIN. A response arriving in the redirect cycle closes that request, so
  // the FSM does not wait for a second one.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (free_cnt >= FW_C) state_n = S_REQ;
      S_REQ:   if (req_accept) state_n = S_RESP;
      S_RESP: begin
        if (cache_resp_valid) begin
`ifdef FETCH_HALT_ON_ZERO_EN
          state_n = zero_stop ? S_HALT : S_IDLE;
`else
          state_n = S_IDLE;
`endif
        end
      end
      S_DRAIN: if (cache_resp_valid) state_n = S_IDLE;
`ifdef FETCH_HALT_ON_ZERO_EN
      S_HALT:  state_n = S_HALT;
`endif
      default: state_n = S_IDLE;
    endcase
    if (in_branch_taken_bool) begin
      if ((((state == S_RESP) || (state == S_DRAIN)) && !cache_resp_valid) ||
          ((state == S_REQ) && req_accept))
        state_n = S_DRAIN;
      else
        state_n = S_IDLE;
    end
  end

  always_comb begin
    fetch_pc_n = fetch_pc;
    if (in_branch_taken_bool) fetch_pc_n = in_target;
    else if (resp_fire)       fetch_pc_n = group_addr + GROUP_BYTES;
  end

  // cache_req_valid is registered from the next state. It therefore rises in
  // the same cycle that the state register first reads REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      req_valid_q <= (state_n == S_REQ);
    end
  end

  // Queue bookkeeping. The request decision in IDLE uses the occupancy from
  // before this cycle's pop and push.
  always_comb begin
    rd_ptr_n      = rd_ptr + PTR_W'(deq);
    cnt_after_deq = count - CNT_W'(deq);
    count_n       = cnt_after_deq + (resp_fire ? CNT_W'(enq_cnt) : '0);
  end

  always_ff @(posedge clk) begin
    if (resp_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (SLOT_W'(i) < enq_cnt) begin
          mem_instr[wr_ptr + PTR_W'(i)] <= enq_data[i];
          mem_pc[wr_ptr + PTR_W'(i)]    <= enq_pcs[i];
        end
      end
    end
  end

  // Head registers. When the queue empties, they keep their last value. When
  // the queue is empty after the pop, a same-cycle push bypasses straight
  // into the head registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else if (in_branch_taken_bool) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_ptr      <= rd_ptr_n;
      wr_ptr      <= wr_ptr + (resp_fire ? PTR_W'(enq_cnt) : '0);
      count       <= count_n;
      out_valid_q <= (count_n != '0);
      if (cnt_after_deq != '0) begin
        out_instr_q <= mem_instr[rd_ptr_n];
        out_pc_q    <= mem_pc[rd_ptr_n];
      end else if (resp_fire && (enq_cnt != '0)) begin
        out_instr_q <= enq_data[0];
        out_pc_q    <= enq_pcs[0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue using the default parameters
// (64-bit PC, 32-bit instructions, FETCH_WIDTH=2, QUEUE_DEPTH=4, RESET_PC=0).
// The cache is driven by hand, so the bench decides exactly when each request
// is accepted and when each response arrives.

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_branch_taken_bool;
  logic [63:0] in_target;
  logic        cache_req_valid;
  logic [63:0] cache_req_addr;
  logic        cache_req_ready;
  logic        cache_resp_valid;
  logic [63:0] cache_resp_data;
  logic        out_valid;
  logic [31:0] out_instruction_bits;
  logic [63:0] out_pc;
  logic        in_enable;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  fetch_queue dut (
    .clk                  (clk),
    .reset                (reset),
    .in_branch_taken_bool (in_branch_taken_bool),
    .in_target            (in_target),
    .cache_req_valid      (cache_req_valid),
    .cache_req_addr       (cache_req_addr),
    .cache_req_ready      (cache_req_ready),
    .cache_resp_valid     (cache_resp_valid),
    .cache_resp_data      (cache_resp_data),
    .out_valid            (out_valid),
    .out_instruction_bits (out_instruction_bits),
    .out_pc               (out_pc),
    .in_enable            (in_enable)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  function automatic logic [63:0] group_data(input logic [63:0] addr);
    return {inst_of(addr + 64'd4), inst_of(addr)};
  endfunction

  // The request must already be valid. Accept it, then answer it on the
  // very next cycle.
  task automatic accept_and_respond(input logic [63:0] data);
    cache_req_ready = 1'b1;
    tick();
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b1;
    cache_resp_data  = data;
    tick();
    cache_resp_valid = 1'b0;
    cache_resp_data  = '0;
  endtask

  task automatic redirect(input logic [63:0] target);
    in_branch_taken_bool = 1'b1;
    in_target            = target;
    tick();
    in_branch_taken_bool = 1'b0;
    in_target            = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_branch_taken_bool = 1'b0; in_target = '0;
    cache_req_ready = 1'b0; cache_resp_valid = 1'b0; cache_resp_data = '0;
    in_enable = 1'b0;
    repeat (3) tick();
    n_checks++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b expected 0", cache_req_valid); end
    n_checks++; if (cache_req_addr !== 64'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 0", cache_req_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_instruction_bits !== 32'h0) begin n_fail++; $display("FAIL reset_out_bits: got %h expected 0", out_instruction_bits); end
    n_checks++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    reset = 1'b0;
    n_checks++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL release_req_valid: got %0b expected 0", cache_req_valid); end
  endtask

  task automatic test_cold_start();
    tick();
    n_checks++; if (cache_req_valid !== 1'b1) begin n_fail++; $display("FAIL cold_req_valid: got %0b expected 1", cache_req_valid); end
    n_checks++; if (cache_req_addr !== 64'h0) begin n_fail++; $display("FAIL cold_req_addr: got %h expected 0", cache_req_addr); end
    accept_and_respond({32'h00200093, 32'h00100093});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cold_out_valid0: got %0b expected 1", out_valid); end
    n_checks++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL cold_out_pc0: got %h expected 0", out_pc); end
    n_checks++; if (out_instruction_bits !== 32'h00100093) begin n_fail++; $display("FAIL cold_out_bits0: got %h expected 00100093", out_instruction_bits); end
    in_enable = 1'b1; tick(); in_enable = 1'b0;
    n_checks++; if (out_pc !== 64'h4) begin n_fail++; $display("FAIL cold_out_pc1: got %h expected 4", out_pc); end
    n_checks++; if (out_instruction_bits !== 32'h00200093) begin n_fail++; $display("FAIL cold_out_bits1: got %h expected 00200093", out_instruction_bits); end
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h8) begin n_fail++; $display("FAIL cold_next_req: got v=%0b a=%h expected v=1 a=8", cache_req_valid, cache_req_addr); end
    in_enable = 1'b1; tick(); in_enable = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cold_empty: got %0b expected 0", out_valid); end
    n_checks++; if (out_pc !== 64'h4) begin n_fail++; $display("FAIL cold_hold_pc: got %h expected 4", out_pc); end
  endtask

  // Redirect to 0x104 while the request for 0x8 sits unaccepted.
  task automatic test_misaligned_redirect();
    redirect(64'h104);
    n_checks++; if (cache_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_n1: got req=%0b out=%0b expected 0 0", cache_req_valid, out_valid); end
    tick();
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h100) begin n_fail++; $display("FAIL mis_req: got v=%0b a=%h expected v=1 a=100", cache_req_valid, cache_req_addr); end
    accept_and_respond({32'h00400093, 32'h00300093});
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h104) begin n_fail++; $display("FAIL mis_head_pc: got v=%0b pc=%h expected v=1 pc=104", out_valid, out_pc); end
    n_checks++; if (out_instruction_bits !== 32'h00400093) begin n_fail++; $display("FAIL mis_head_bits: got %h expected 00400093", out_instruction_bits); end
    tick();
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h108) begin n_fail++; $display("FAIL mis_next_req: got v=%0b a=%h expected v=1 a=108", cache_req_valid, cache_req_addr); end
    in_enable = 1'b1; tick(); in_enable = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_single_entry: got %0b expected 0", out_valid); end
  endtask

  // Request 0x108 accepted, redirect in RESP, stale response two cycles later.
  task automatic test_redirect_in_resp();
    cache_req_ready = 1'b1; tick(); cache_req_ready = 1'b0;
    redirect(64'h200);
    n_checks++; if (out_valid !== 1'b0 || cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL drain_n1: got out=%0b req=%0b expected 0 0", out_valid, cache_req_valid); end
    tick();
    cache_resp_valid = 1'b1; cache_resp_data = {32'hDEAD0013, 32'hBEEF0013};
    tick();
    cache_resp_valid = 1'b0; cache_resp_data = '0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_stale_dropped: got %0b expected 0", out_valid); end
    tick();
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h200) begin n_fail++; $display("FAIL drain_target_req: got v=%0b a=%h expected v=1 a=200", cache_req_valid, cache_req_addr); end
    accept_and_respond({32'h00600093, 32'h00500093});
    n_checks++; if (out_pc !== 64'h200 || out_instruction_bits !== 32'h00500093) begin n_fail++; $display("FAIL drain_new_head: got pc=%h i=%h expected pc=200 i=00500093", out_pc, out_instruction_bits); end
  endtask

  // Decode stalls for 10 cycles: only two groups fit, then the fetcher waits.
  task automatic test_backpressure();
    logic        pending;
    logic [63:0] pend_addr;
    int          accepted;
    in_enable = 1'b1; tick(); tick(); in_enable = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || cache_req_valid !== 1'b1 || cache_req_addr !== 64'h208) begin n_fail++; $display("FAIL bp_start: got out=%0b req=%0b a=%h expected 0 1 208", out_valid, cache_req_valid, cache_req_addr); end
    exp_q.push_back(64'h208); exp_q.push_back(64'h20C);
    exp_q.push_back(64'h210); exp_q.push_back(64'h214);
    pending = 1'b0; pend_addr = '0; accepted = 0;
    cache_req_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cache_resp_valid = pending;
      cache_resp_data  = pending ? group_data(pend_addr) : '0;
      pending = cache_req_valid & cache_req_ready;
      if (pending) begin
        pend_addr = cache_req_addr;
        accepted++;
      end
      tick();
    end
    cache_req_ready = 1'b0; cache_resp_valid = 1'b0; cache_resp_data = '0;
    n_checks++; if (accepted != 2) begin n_fail++; $display("FAIL bp_groups: got %0d expected 2", accepted); end
    n_checks++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_third_req: got %0b expected 0", cache_req_valid); end
    for (int i = 0; i < 4; i++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== e || out_instruction_bits !== inst_of(e)) begin n_fail++; $display("FAIL bp_drain%0d: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", i, out_valid, out_pc, out_instruction_bits, e, inst_of(e)); end
      in_enable = 1'b1; tick(); in_enable = 1'b0;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0b expected 0", out_valid); end
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h218) begin n_fail++; $display("FAIL bp_next_req: got v=%0b a=%h expected v=1 a=218", cache_req_valid, cache_req_addr); end
  endtask

  // Response and redirect in the same cycle with a non-empty queue.
  task automatic test_resp_with_redirect();
    accept_and_respond(group_data(64'h218));
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h218) begin n_fail++; $display("FAIL rr_fill: got v=%0b pc=%h expected v=1 pc=218", out_valid, out_pc); end
    tick();
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h220) begin n_fail++; $display("FAIL rr_req: got v=%0b a=%h expected v=1 a=220", cache_req_valid, cache_req_addr); end
    cache_req_ready = 1'b1; tick(); cache_req_ready = 1'b0;
    cache_resp_valid = 1'b1; cache_resp_data = group_data(64'h220);
    redirect(64'h300);
    cache_resp_valid = 1'b0; cache_resp_data = '0;
    n_checks++; if (out_valid !== 1'b0 || cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL rr_flushed: got out=%0b req=%0b expected 0 0", out_valid, cache_req_valid); end
    tick();
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h300) begin n_fail++; $display("FAIL rr_target_req: got v=%0b a=%h expected v=1 a=300", cache_req_valid, cache_req_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_no_enqueue: got %0b expected 0", out_valid); end
  endtask

  // Reset while a request is outstanding; no stale response is delivered.
  task automatic test_reset_mid_op();
    cache_req_ready = 1'b1; tick(); cache_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (cache_req_valid !== 1'b0 || cache_req_addr !== 64'h0) begin n_fail++; $display("FAIL midrst_req: got v=%0b a=%h expected v=0 a=0", cache_req_valid, cache_req_addr); end
    n_checks++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instruction_bits !== 32'h0) begin n_fail++; $display("FAIL midrst_out: got v=%0b pc=%h i=%h expected all 0", out_valid, out_pc, out_instruction_bits); end
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h0) begin n_fail++; $display("FAIL midrst_restart: got v=%0b a=%h expected v=1 a=0", cache_req_valid, cache_req_addr); end
  endtask

`ifdef FETCH_HALT_ON_ZERO_EN
  task automatic test_zero_word();
    accept_and_respond({32'h00100093, 32'h00000000});
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_no_enqueue: got %0b expected 0", out_valid); end
    tick(); tick();
    n_checks++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_no_req: got %0b expected 0", cache_req_valid); end
    redirect(64'h40);
    tick();
    n_checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h40) begin n_fail++; $display("FAIL halt_redirect_req: got v=%0b a=%h expected v=1 a=40", cache_req_valid, cache_req_addr); end
  endtask
`else
  task automatic test_zero_word();
    accept_and_respond({32'h00100093, 32'h00000000});
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instruction_bits !== 32'h0) begin n_fail++; $display("FAIL zero_is_ordinary: got v=%0b pc=%h i=%h expected v=1 pc=0 i=0", out_valid, out_pc, out_instruction_bits); end
    in_enable = 1'b1; tick(); in_enable = 1'b0;
    n_checks++; if (out_pc !== 64'h4 || out_instruction_bits !== 32'h00100093) begin n_fail++; $display("FAIL zero_second_slot: got pc=%h i=%h expected pc=4 i=00100093", out_pc, out_instruction_bits); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cold_start();
    test_misaligned_redirect();
    test_redirect_in_resp();
    test_backpressure();
    test_resp_with_redirect();
    test_reset_mid_op();
    test_zero_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
